apb_add_master: RTL and testbench

- Single-transfer APB (AMBA3-style) master driven by a 2-bit command input.
- A READ command fetches a 32-bit word from a fixed target address and stores it locally.
- A WRITE command writes the stored word plus one back to the same address (read-modify-write increment).
- Sits between local control logic and one APB slave; one outstanding transfer at a time.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_add_master_if.sv | 23 ++
 rtl/apb_add_master.sv | 80 ++++++++
 tb/tb_apb_add_master.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB read-modify-write increment master.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam logic [1:0]  CMD_NOP   = 2'b00;
    localparam logic [1:0]  CMD_READ  = 2'b01;
    localparam logic [1:0]  CMD_WRITE = 2'b11;

    localparam logic [31:0] TGT_ADDR_DEFAULT = 32'h0000_A000;

endpackage

// File: rtl/apb_add_master_if.sv
// APB bus bundle between the increment master and a single slave.
interface apb_add_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_add_master.sv
// Single-transfer APB master: READ fetches a word from a fixed address,
// WRITE stores that word plus one back to the same address.
module apb_add_master
    import apb_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] TGT_ADDR = ADDR_W'(TGT_ADDR_DEFAULT)
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic [1:0]  add_i,
    apb_add_master_if.master apb
);

    apb_state_t        r_state;
    apb_state_t        w_state_nxt;
    logic              r_op_wr;
    logic              w_op_wr_nxt;
    logic [DATA_W-1:0] r_rdata;

    logic              w_active;
    logic              w_done;

    assign w_active = (r_state != ST_IDLE);
    assign w_done   = (r_state == ST_ACCESS) && apb.pready;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= ST_IDLE;
            r_op_wr <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op_wr <= w_op_wr_nxt;
            if (w_done && !r_op_wr) begin
                r_rdata <= apb.prdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_wr_nxt = r_op_wr;
        case (r_state)
            ST_IDLE: begin
                // 2'b10 falls through as a NOP
                if (add_i == CMD_READ) begin
                    w_op_wr_nxt = 1'b0;
                    w_state_nxt = ST_SETUP;
                end else if (add_i == CMD_WRITE) begin
                    w_op_wr_nxt = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (apb.pready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs depend only on registered state, op and read data.
    always_comb begin
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.paddr   = '0;
        apb.pwrite  = 1'b0;
        apb.pwdata  = '0;
        if (w_active) begin
            apb.psel    = 1'b1;
            apb.penable = (r_state == ST_ACCESS);
            apb.paddr   = TGT_ADDR;
            apb.pwrite  = r_op_wr;
            if (r_op_wr) begin
                apb.pwdata = r_rdata + DATA_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_apb_add_master.sv
// Scoreboard bench: stimulus queues expected transfers, a monitor checks the bus.
module tb_apb_add_master;
    import apb_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
    } exp_t;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic [1:0]  add_i = 2'b00;

    exp_t        q[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned n_done = 0;
    int unsigned n_exp_done = 0;
    bit          sim_done = 1'b0;

    apb_add_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_add_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TGT_ADDR(32'h0000_A000)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .add_i (add_i),
        .apb   (bus.master)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One complete transfer: command pulse, then a slave with ws wait states.
    task automatic xfer(input logic [1:0] cmd, input int unsigned ws,
                        input logic [31:0] rd, input logic [1:0] mid,
                        input logic [31:0] exp_wd);
        q.push_back('{wr: (cmd == CMD_WRITE), addr: 32'h0000_A000, wd: exp_wd});
        n_exp_done++;
        @(negedge pclk);
        add_i = cmd;
        bus.pready = 1'b0;
        bus.prdata = 32'hDEAD_BEEF;
        @(posedge pclk);
        #1 chk("lat_setup", {bus.psel, bus.penable}, 32'h2);
        @(negedge pclk);
        add_i = 2'b00;
        @(posedge pclk);
        #1 chk("lat_access", {bus.psel, bus.penable}, 32'h3);
        for (int unsigned c = 1; c <= ws + 1; c++) begin
            @(negedge pclk);
            add_i      = (c <= ws) ? mid : 2'b00;
            bus.pready = (c > ws);
            bus.prdata = (c > ws) ? rd : 32'hDEAD_BEEF;
            @(posedge pclk);
        end
        @(negedge pclk);
        bus.pready = 1'b0;
        bus.prdata = 32'hDEAD_BEEF;
    endtask

    // Monitor / scoreboard
    initial begin
        bit active = 1'b0;
        bit prev_setup = 1'b0;
        bit just_done = 1'b0;
        while (!sim_done) begin
            @(negedge pclk);
            #1;
            if (preset) begin
                if (active) begin
                    void'(q.pop_front());
                    active = 1'b0;
                end
                chk("rst_outs", {bus.psel, bus.penable, bus.pwrite}, 32'h0);
                chk("rst_paddr", bus.paddr, 32'h0);
                chk("rst_pwdata", bus.pwdata, 32'h0);
                prev_setup = 1'b0;
                just_done  = 1'b0;
            end else if (bus.psel && !bus.penable) begin
                chk("setup_once", prev_setup, 32'h0);
                chk("gap_after_done", just_done, 32'h0);
                if (q.size() == 0) begin
                    chk("unexpected_xfer", q.size(), 32'h1);
                end else begin
                    chk("setup_pwrite", bus.pwrite, q[0].wr);
                    chk("setup_paddr", bus.paddr, q[0].addr);
                    chk("setup_pwdata", bus.pwdata, q[0].wd);
                    active = 1'b1;
                end
                prev_setup = 1'b1;
                just_done  = 1'b0;
            end else if (bus.psel && bus.penable) begin
                chk("access_after_setup", active, 32'h1);
                if (active) begin
                    chk("access_pwrite", bus.pwrite, q[0].wr);
                    chk("access_paddr", bus.paddr, q[0].addr);
                    chk("access_pwdata", bus.pwdata, q[0].wd);
                    if (bus.pready) begin
                        void'(q.pop_front());
                        n_done++;
                        active    = 1'b0;
                        just_done = 1'b1;
                    end else begin
                        just_done = 1'b0;
                    end
                end
                prev_setup = 1'b0;
            end else begin
                chk("idle_ctl", {bus.penable, bus.pwrite}, 32'h0);
                chk("idle_paddr", bus.paddr, 32'h0);
                chk("idle_pwdata", bus.pwdata, 32'h0);
                chk("idle_no_lost_xfer", active, 32'h0);
                prev_setup = 1'b0;
                just_done  = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin
        bus.pready = 1'b0;
        bus.prdata = 32'h0;
        repeat (2) @(posedge pclk);
        #1 chk("reset_psel", bus.psel, 32'h0);
        @(negedge pclk);
        preset = 1'b0;
        repeat (4) @(posedge pclk);

        xfer(CMD_WRITE, 0, 32'h0, 2'b00, 32'h0000_0001);
        xfer(CMD_READ,  1, 32'h0000_0013, 2'b00, 32'h0);
        xfer(CMD_WRITE, 0, 32'h0, 2'b00, 32'h0000_0014);
        xfer(CMD_READ,  0, 32'hFFFF_FFFF, 2'b00, 32'h0);
        xfer(CMD_WRITE, 2, 32'h5555_5555, 2'b00, 32'h0000_0000);
        xfer(CMD_READ,  3, 32'h0000_1234, CMD_WRITE, 32'h0);
        xfer(CMD_WRITE, 3, 32'h7777_7777, CMD_WRITE, 32'h0000_1235);
        xfer(CMD_READ,  0, 32'h0000_0007, 2'b00, 32'h0);
        xfer(CMD_WRITE, 0, 32'h0, 2'b00, 32'h0000_0008);

        // Reset during ACCESS of a read: outputs clear without a clock edge.
        q.push_back('{wr: 1'b0, addr: 32'h0000_A000, wd: 32'h0});
        @(negedge pclk);
        add_i      = CMD_READ;
        bus.prdata = 32'hCAFE_0001;
        @(posedge pclk);
        @(negedge pclk);
        add_i = 2'b00;
        @(posedge pclk);
        #1 chk("pre_abort_access", {bus.psel, bus.penable}, 32'h3);
        #2 preset = 1'b1;
        #1 chk("abort_ctl", {bus.psel, bus.penable, bus.pwrite}, 32'h0);
        chk("abort_paddr", bus.paddr, 32'h0);
        @(posedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        add_i  = 2'b10;
        repeat (4) @(posedge pclk);
        @(negedge pclk);
        add_i = 2'b00;

        xfer(CMD_WRITE, 1, 32'h0, 2'b00, 32'h0000_0001);

        repeat (3) @(posedge pclk);
        #1;
        sim_done = 1'b1;
        chk("queue_drained", q.size(), 32'h0);
        chk("completions", n_done, n_exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
